// File: rtl/wbs_banked_mem_port_if.sv
// wbs_banked_mem_port_if: Wishbone classic slave bus bundle (stb/cyc/we/sel/dat/adr in, ack/dat out)
interface wbs_banked_mem_port_if;
  logic wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_ack_o;
  logic [3:0] wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i, wbs_dat_o;
  modport master(output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, input wbs_ack_o, wbs_dat_o);
  modport slave(input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wbs_banked_mem_port.sv
// wbs_banked_mem_port: Wishbone word access to NUM_BANKS wide SRAM banks (wbs bus, wbs_debug enable, mem_* SRAM port 0)
module wbs_banked_mem_port #(
  parameter int MEM_WIDTH = 64,
  parameter int MEM_DEPTH = 64,
  parameter int NUM_BANKS = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3200_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFF00_0000,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_W = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  wbs_banked_mem_port_if.slave wbs,
  input  logic wbs_debug,
  output logic [NUM_BANKS-1:0] mem_csb0,
  output logic [NUM_BANKS-1:0] mem_web0,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [MEM_WIDTH-1:0] mem_wdata0,
  input  logic [NUM_BANKS*MEM_WIDTH-1:0] mem_rdata0
);
  localparam int W = (MEM_WIDTH + 31) / 32;
  localparam int WS_W = W > 1 ? $clog2(W) : 1;
  localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int EW = W * 32;
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, ACK} state_t;
  state_t state, state_d;
  logic [EW-1:0] stage, stage_d, rbuf, rbuf_d, wfull;
  logic rvalid, rvalid_d;
  logic [BANK_W+ADDR_W-1:0] tag, tag_d;
  logic [WS_W-1:0] word, word_d, a_word;
  logic [BANK_W-1:0] bank, bank_d, a_bank;
  logic [ADDR_W-1:0] entry, entry_d, a_entry;
  logic [MEM_WIDTH-1:0] wdata, wdata_d;
  logic [31:0] dat, dat_d;
  logic [2:0] cnt, cnt_d;
  logic req, bad, hit, top;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) merge[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
  endfunction
  assign a_word = wbs.wbs_adr_i[WS_W-1:0];
  assign a_bank = wbs.wbs_adr_i[WS_W +: BANK_W];
  assign a_entry = wbs.wbs_adr_i[WS_W+BANK_W +: ADDR_W];
  assign req = wbs.wbs_stb_i && wbs.wbs_cyc_i && ((wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign bad = !wbs_debug || 32'(a_word) >= W || 32'(a_bank) >= NUM_BANKS || 32'(a_entry) >= MEM_DEPTH;
  // word 0 always refetches so a fresh read sequence never sees stale SRAM contents
  assign hit = rvalid && tag == {a_bank, a_entry} && a_word != '0;
  assign top = 32'(a_word) == W - 1;
  always_comb begin
    state_d = state;
    stage_d = stage;
    rbuf_d = rbuf;
    rvalid_d = rvalid;
    tag_d = tag;
    word_d = word;
    bank_d = bank;
    entry_d = entry;
    wdata_d = wdata;
    dat_d = dat;
    cnt_d = cnt;
    wfull = stage;
    wfull[int'(a_word)*32 +: 32] = merge(stage[int'(a_word)*32 +: 32], wbs.wbs_dat_i, wbs.wbs_sel_i);
    case (state)
      IDLE: if (req) begin
        word_d = a_word;
        bank_d = a_bank;
        entry_d = a_entry;
        state_d = ACK;
        if (bad || wbs.wbs_we_i) dat_d = '0;
        if (bad) state_d = ACK;
        else if (wbs.wbs_we_i && top) begin
          wdata_d = wfull[MEM_WIDTH-1:0];
          state_d = WRITE;
        end else if (wbs.wbs_we_i) stage_d = wfull;
        else if (hit) dat_d = rbuf[int'(a_word)*32 +: 32];
        else begin
          cnt_d = '0;
          state_d = READ;
        end
      end
      WRITE: begin
        stage_d = '0;
        // keep the read buffer coherent with the entry just committed
        if (rvalid && tag == {bank, entry}) rbuf_d = EW'(wdata);
        state_d = ACK;
      end
      READ: state_d = WAIT;
      WAIT: if (cnt == 3'(READ_LATENCY - 1)) begin
        rbuf_d = EW'(mem_rdata0[int'(bank)*MEM_WIDTH +: MEM_WIDTH]);
        rvalid_d = 1'b1;
        tag_d = {bank, entry};
        dat_d = rbuf_d[int'(word)*32 +: 32];
        state_d = ACK;
      end else cnt_d = cnt + 3'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      stage <= '0;
      rbuf <= '0;
      rvalid <= 1'b0;
      tag <= '0;
      word <= '0;
      bank <= '0;
      entry <= '0;
      wdata <= '0;
      dat <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      stage <= stage_d;
      rbuf <= rbuf_d;
      rvalid <= rvalid_d;
      tag <= tag_d;
      word <= word_d;
      bank <= bank_d;
      entry <= entry_d;
      wdata <= wdata_d;
      dat <= dat_d;
      cnt <= cnt_d;
    end
  end
  assign wbs.wbs_ack_o = state == ACK;
  assign wbs.wbs_dat_o = dat;
  assign mem_csb0 = (state == WRITE || state == READ) ? ~(NUM_BANKS'(1) << bank) : '1;
  assign mem_web0 = state == WRITE ? ~(NUM_BANKS'(1) << bank) : '1;
  assign mem_addr0 = entry;
  assign mem_wdata0 = wdata;
endmodule

// File: tb/tb_wbs_banked_mem_port.sv
// tb_wbs_banked_mem_port: directed vector bench for a default port and a 6-bank/55-bit/latency-3 port
module tb_wbs_banked_mem_port;
  localparam logic [31:0] B = 32'h3200_0000;
  typedef struct {
    logic tgt, dbg, we;
    logic [31:0] adr, dat;
    logic [3:0] sel;
    logic ack;
    int lat;
    logic [31:0] rd;
    int nstb;
    logic [7:0] csb;
    logic [63:0] wd;
  } vec_t;
  logic clk = 0, rst = 1, tgt = 0, dbg = 1, stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] dat = 0, adr = 0;
  logic [7:0] csb0, web0;
  logic [5:0] csb1, web1, addr0, addr1;
  logic [63:0] wd0;
  logic [54:0] wd1;
  logic [8*64-1:0] rd0;
  logic [6*55-1:0] rd1;
  logic cur_ack;
  logic [31:0] cur_dat;
  logic [7:0] cur_csb, cur_web;
  logic [5:0] cur_addr;
  logic [63:0] cur_wd;
  int ncmp = 0, nbad = 0;
  vec_t v[16];
  logic r_ack, seen;
  int r_lat, r_nstb;
  logic [31:0] r_dat;
  logic [7:0] r_cs, r_ws;
  logic [5:0] r_ad;
  logic [63:0] r_wd;
  always #5 clk = ~clk;
  wbs_banked_mem_port_if b0();
  wbs_banked_mem_port_if b1();
  assign b0.wbs_stb_i = stb && !tgt;
  assign b1.wbs_stb_i = stb && tgt;
  assign b0.wbs_cyc_i = cyc;
  assign b1.wbs_cyc_i = cyc;
  assign b0.wbs_we_i = we;
  assign b1.wbs_we_i = we;
  assign b0.wbs_sel_i = sel;
  assign b1.wbs_sel_i = sel;
  assign b0.wbs_dat_i = dat;
  assign b1.wbs_dat_i = dat;
  assign b0.wbs_adr_i = adr;
  assign b1.wbs_adr_i = adr;
  wbs_banked_mem_port u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(b0), .wbs_debug(dbg),
    .mem_csb0(csb0), .mem_web0(web0), .mem_addr0(addr0), .mem_wdata0(wd0), .mem_rdata0(rd0)
  );
  wbs_banked_mem_port #(.MEM_WIDTH(55), .NUM_BANKS(6), .READ_LATENCY(3)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(b1), .wbs_debug(dbg),
    .mem_csb0(csb1), .mem_web0(web1), .mem_addr0(addr1), .mem_wdata0(wd1), .mem_rdata0(rd1)
  );
  assign cur_ack = tgt ? b1.wbs_ack_o : b0.wbs_ack_o;
  assign cur_dat = tgt ? b1.wbs_dat_o : b0.wbs_dat_o;
  assign cur_csb = tgt ? {2'b11, csb1} : csb0;
  assign cur_web = tgt ? {2'b11, web1} : web0;
  assign cur_addr = tgt ? addr1 : addr0;
  assign cur_wd = tgt ? 64'(wd1) : wd0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t t);
    r_ack = 0; r_lat = 0; r_dat = 0; r_nstb = 0; r_cs = '1; r_ws = '1; r_ad = 0; r_wd = 0;
    @(negedge clk);
    tgt = t.tgt; dbg = t.dbg; we = t.we; adr = t.adr; dat = t.dat; sel = t.sel; stb = 1; cyc = 1;
    for (int c = 1; c <= 10 && !r_ack; c++) begin
      @(negedge clk);
      if (cur_csb != 8'hFF) begin
        r_nstb++; r_cs = cur_csb; r_ws = cur_web; r_ad = cur_addr; r_wd = cur_wd;
      end
      if (cur_ack) begin
        r_ack = 1; r_lat = c; r_dat = cur_dat;
      end
    end
    stb = 0; cyc = 0;
  endtask
  initial begin
    rd0 = '0;
    rd0[7*64 +: 64] = 64'h1100_1010_DEAD_BEEF;
    rd0[3*64 +: 64] = 64'h0123_4567_89AB_CDEF;
    rd1 = '0;
    rd1[2*55 +: 55] = 55'h00_1010_DEAD_BEEF;
    v[0]  = '{0, 1, 0, B + 'hE, 0, 'hF, 1, 3, 32'hDEADBEEF, 1, 8'h7F, 0};
    v[1]  = '{0, 1, 0, B + 'hF, 0, 'hF, 1, 1, 32'h11001010, 0, 8'hFF, 0};
    v[2]  = '{0, 0, 0, B + 'hE, 0, 'hF, 1, 1, 32'h0, 0, 8'hFF, 0};
    v[3]  = '{0, 1, 1, B + 'h6, 32'h76543210, 'hF, 1, 1, 0, 0, 8'hFF, 0};
    v[4]  = '{0, 1, 1, B + 'h7, 32'hFEDCBA98, 'hF, 1, 2, 0, 1, 8'hF7, 64'hFEDCBA98_76543210};
    v[5]  = '{0, 1, 0, B + 'h6, 0, 'hF, 1, 3, 32'h89ABCDEF, 1, 8'hF7, 0};
    v[6]  = '{0, 1, 1, B + 'h6, 32'hAABBCCDD, 4'h3, 1, 1, 0, 0, 8'hFF, 0};
    v[7]  = '{0, 1, 1, B + 'h7, 0, 'hF, 1, 2, 0, 1, 8'hF7, 64'h0000_0000_0000_CCDD};
    v[8]  = '{0, 1, 0, B + 'h7, 0, 'hF, 1, 1, 32'h0, 0, 8'hFF, 0};
    v[9]  = '{0, 1, 0, 32'h3300_000E, 0, 'hF, 0, 0, 0, 0, 8'hFF, 0};
    v[10] = '{1, 1, 0, B + 'h4, 0, 'hF, 1, 5, 32'hDEADBEEF, 1, 8'hFB, 0};
    v[11] = '{1, 1, 0, B + 'h5, 0, 'hF, 1, 1, 32'h00001010, 0, 8'hFF, 0};
    v[12] = '{1, 1, 0, B + 'hE, 0, 'hF, 1, 1, 32'h0, 0, 8'hFF, 0};
    v[13] = '{1, 1, 1, B + 'h4, 0, 'hF, 1, 1, 0, 0, 8'hFF, 0};
    v[14] = '{1, 1, 1, B + 'h5, 32'hFFFFFFFF, 'hF, 1, 2, 0, 1, 8'hFB, 64'h007F_FFFF_0000_0000};
    v[15] = '{1, 1, 0, B + 'h5, 0, 'hF, 1, 1, 32'h007FFFFF, 0, 8'hFF, 0};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset ack", 64'(b0.wbs_ack_o), 0);
    check("reset dat", 64'(b0.wbs_dat_o), 0);
    check("reset csb", 64'({csb1, csb0}), 64'h3FFF);
    check("reset web", 64'({web1, web0}), 64'h3FFF);
    check("reset addr", 64'(addr0), 0);
    check("reset wdata", wd0, 0);
    for (int i = 0; i < 16; i++) begin
      run(v[i]);
      check($sformatf("v%0d ack", i), 64'(r_ack), 64'(v[i].ack));
      if (v[i].ack) check($sformatf("v%0d latency", i), 64'(r_lat), 64'(v[i].lat));
      if (v[i].ack && !v[i].we) check($sformatf("v%0d rdata", i), 64'(r_dat), 64'(v[i].rd));
      check($sformatf("v%0d strobes", i), 64'(r_nstb), 64'(v[i].nstb));
      if (v[i].nstb > 0) begin
        check($sformatf("v%0d csb", i), 64'(r_cs), 64'(v[i].csb));
        check($sformatf("v%0d web", i), 64'(r_ws), v[i].we ? 64'(v[i].csb) : 64'hFF);
        check($sformatf("v%0d addr", i), 64'(r_ad), 0);
        if (v[i].we) check($sformatf("v%0d wdata", i), r_wd, v[i].wd);
      end
    end
    // reset while the latency-3 port sits in WAIT
    @(negedge clk);
    tgt = 1; dbg = 1; we = 0; adr = B + 'h4; stb = 1; cyc = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1; stb = 0; cyc = 0;
    @(negedge clk);
    rst = 0;
    check("mid-read reset ack", 64'(b1.wbs_ack_o), 0);
    check("mid-read reset dat", 64'(b1.wbs_dat_o), 0);
    check("mid-read reset csb", 64'(csb1), 64'h3F);
    check("mid-read reset web", 64'(web1), 64'h3F);
    check("mid-read reset addr", 64'(addr1), 0);
    check("mid-read reset wdata", 64'(wd1), 0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen = seen | b1.wbs_ack_o | (csb1 != 6'h3F);
    end
    check("mid-read no ack", 64'(seen), 0);
    run('{1, 1, 0, B + 'h5, 0, 'hF, 1, 5, 32'h00001010, 1, 8'hFB, 0});
    check("post-reset ack", 64'(r_ack), 1);
    check("post-reset latency", 64'(r_lat), 5);
    check("post-reset strobes", 64'(r_nstb), 1);
    check("post-reset rdata", 64'(r_dat), 64'h1010);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
